// File: rtl/ft600_pkg.sv
// Shared definitions for the FT600 TX arbiter: word width, frame tags,
// arbiter state encoding and frame-word builders.
package ft600_pkg;

  localparam int FT_DATA_W = 16;

  localparam logic [3:0] HDR_TAG = 4'hD;
  localparam logic [3:0] TRL_TAG = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_TRL  = 2'd3
  } arb_state_t;

  // Header word: tag, source id, zero pad.
  function automatic logic [FT_DATA_W-1:0] hdr_word(input logic [3:0] id);
    return {HDR_TAG, id, 8'h00};
  endfunction

  // Trailer word: tag, source id, number of data words in the burst.
  function automatic logic [FT_DATA_W-1:0] trl_word(input logic [3:0] id,
                                                    input logic [7:0] n);
    return {TRL_TAG, id, n};
  endfunction

endpackage

// File: rtl/ft600_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit starting at
// last+1 and wrapping modulo NUM_SRC.
module rr_pick
  import ft600_pkg::*;
#(
  parameter int NUM_SRC = 4
)(
  input  logic [NUM_SRC-1:0] req,
  input  logic [3:0]         last,
  output logic [3:0]         idx,
  output logic               vld
);

  logic [15:0] req_pad;
  logic [3:0]  cand;

  assign req_pad = 16'(req);

  // Walk candidates from farthest to nearest so the nearest hit after last wins.
  always_comb begin
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      cand = 4'((int'(last) + i) % NUM_SRC);
      if (req_pad[cand]) begin
        idx = cand;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ft600_tx_arbiter.sv
// Round-robin arbiter sharing the FT600 mode-245 TX write port between
// NUM_SRC FWFT stream sources. Each grant is sent as header, 1..MAX_BURST
// data words from one source, then a trailer carrying the word count.
module ft600_tx_arbiter
  import ft600_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 64
)(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             src_empty,
  input  logic [FT_DATA_W*NUM_SRC-1:0]   src_data,
  output logic [NUM_SRC-1:0]             src_rd,
  output logic                           tx_en,
  output logic [FT_DATA_W-1:0]           tx_in,
  input  logic                           tx_full
);

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
  localparam logic [3:0] LAST_RST  = 4'(NUM_SRC - 1);

  arb_state_t state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] last_q,  last_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [7:0] cnt_inc;

  logic [3:0] pick_idx;
  logic       pick_vld;

  logic [15:0]                empty_pad;
  logic [15:0][FT_DATA_W-1:0] data_pad;
  logic                       sel_empty;
  logic [FT_DATA_W-1:0]       sel_data;
  logic                       rd_any;

  // Unused slots read as permanently empty so a 4-bit grant index is always safe.
  for (genvar g = 0; g < 16; g++) begin : g_pad
    if (g < NUM_SRC) begin : g_src
      assign empty_pad[g] = src_empty[g];
      assign data_pad[g]  = src_data[FT_DATA_W*g +: FT_DATA_W];
    end else begin : g_unused
      assign empty_pad[g] = 1'b1;
      assign data_pad[g]  = '0;
    end
  end

  assign sel_empty = empty_pad[grant_q];
  assign sel_data  = data_pad[grant_q];
  assign cnt_inc   = cnt_q + 8'd1;

  // Only the granted source may ever see a pop strobe.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_rd
    assign src_rd[g] = rd_any & (grant_q == 4'(g));
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req  (~src_empty),
    .last (last_q),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  // State and control registers; reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: advance only on a real write, or on source drain in DATA.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!tx_full) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (sel_empty) begin
          state_d = ST_TRL;
        end else if (!tx_full) begin
          cnt_d = cnt_inc;
          if (cnt_inc == BURST_LIM) begin
            state_d = ST_TRL;
          end
        end
      end
      ST_TRL: begin
        if (!tx_full) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: write strobe, pop strobe and TX word straight from state.
  always_comb begin
    tx_en  = 1'b0;
    tx_in  = '0;
    rd_any = 1'b0;
    case (state_q)
      ST_HDR: begin
        tx_en = ~tx_full;
        tx_in = hdr_word(grant_q);
      end
      ST_DATA: begin
        rd_any = ~tx_full & ~sel_empty;
        tx_en  = rd_any;
        tx_in  = sel_data;
      end
      ST_TRL: begin
        tx_en = ~tx_full;
        tx_in = trl_word(grant_q, cnt_q);
      end
      default: begin
        tx_en  = 1'b0;
        tx_in  = '0;
        rd_any = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ft600_tx_arbiter.sv
// Scoreboard bench for ft600_tx_arbiter: lane 0 uses MAX_BURST=64,
// lane 1 uses MAX_BURST=4. Stimulus queues expected TX words; a monitor
// pops and compares them whenever tx_en is sampled high.
module tb_ft600_tx_arbiter;

  localparam int NS = 4;
  localparam int NL = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NS-1:0]    src_empty [NL] = '{default: '1};
  logic [16*NS-1:0] src_data  [NL] = '{default: '0};
  logic [NS-1:0]    src_rd    [NL];
  logic             tx_en     [NL];
  logic [15:0]      tx_in     [NL];
  logic             tx_full   [NL];

  logic [15:0] srcq [NL][NS][$];
  logic [15:0] expq [NL][$];
  logic [15:0] exp_w;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int nwr     [NL];
  int hdr_cyc [NL];
  int trl_cyc [NL];
  int base;
  int n;

  ft600_tx_arbiter #(.NUM_SRC(NS), .MAX_BURST(64)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_empty (src_empty[0]),
    .src_data  (src_data[0]),
    .src_rd    (src_rd[0]),
    .tx_en     (tx_en[0]),
    .tx_in     (tx_in[0]),
    .tx_full   (tx_full[0])
  );

  ft600_tx_arbiter #(.NUM_SRC(NS), .MAX_BURST(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_empty (src_empty[1]),
    .src_data  (src_data[1]),
    .src_rd    (src_rd[1]),
    .tx_en     (tx_en[1]),
    .tx_in     (tx_in[1]),
    .tx_full   (tx_full[1])
  );

  // FWFT source FIFO model: pop on src_rd, present head word and empty flag.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int l = 0; l < NL; l++) begin
      for (int i = 0; i < NS; i++) begin
        if (src_rd[l][i] && srcq[l][i].size() > 0) void'(srcq[l][i].pop_front());
        src_empty[l][i] <= (srcq[l][i].size() == 0);
        src_data[l][16*i +: 16] <= (srcq[l][i].size() == 0) ? 16'h0000 : srcq[l][i][0];
      end
    end
  end

  // Monitor: compare every written word against the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < NL; l++) begin
        if (tx_full[l]) begin
          checks++;
          if (tx_en[l]) begin
            errors++;
            $display("FAIL en_while_full lane%0d cyc%0d: tx_en=1 required 0", l, cyc);
          end
        end
        if (src_rd[l] != '0) begin
          checks++;
          if ($countones(src_rd[l]) != 1) begin
            errors++;
            $display("FAIL src_rd_onehot lane%0d: src_rd=%b required one-hot", l, src_rd[l]);
          end
        end
        if (tx_en[l]) begin
          checks++;
          if (expq[l].size() == 0) begin
            errors++;
            $display("FAIL unexpected_write lane%0d: tx_in=%h required no write", l, tx_in[l]);
          end else begin
            exp_w = expq[l].pop_front();
            if (tx_in[l] !== exp_w) begin
              errors++;
              $display("FAIL tx_word lane%0d #%0d: tx_in=%h required %h", l, nwr[l], tx_in[l], exp_w);
            end
            if (exp_w[15:12] == 4'hD) hdr_cyc[l] = cyc;
            if (exp_w[15:12] == 4'hE) trl_cyc[l] = cyc;
          end
          nwr[l]++;
        end
      end
    end
  end

  task automatic tick(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("rst_tx_en_l%0d", l), 32'(tx_en[l]), 32'h0);
      chk($sformatf("rst_tx_in_l%0d", l), 32'(tx_in[l]), 32'h0);
      chk($sformatf("rst_src_rd_l%0d", l), 32'(src_rd[l]), 32'h0);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic load(input int l, input int s, input logic [15:0] first, input int cnt);
    for (int k = 0; k < cnt; k++) srcq[l][s].push_back(first + 16'(k));
  endtask

  task automatic expect_burst(input int l, input int s, input logic [15:0] first, input int cnt);
    expq[l].push_back({4'hD, 4'(s), 8'h00});
    for (int k = 0; k < cnt; k++) expq[l].push_back(first + 16'(k));
    expq[l].push_back({4'hE, 4'(s), 8'(cnt)});
  endtask

  task automatic wait_drain(input int l, input int budget);
    int w = 0;
    while (expq[l].size() != 0 && w < budget) begin
      tick(1);
      w++;
    end
    checks++;
    if (expq[l].size() != 0) begin
      errors++;
      $display("FAIL drain lane%0d: %0d words outstanding required 0", l, expq[l].size());
      expq[l].delete();
    end
    tick(4);
  endtask

  initial begin
    tx_full[0] = 1'b0;
    tx_full[1] = 1'b0;
    for (int l = 0; l < NL; l++) begin
      nwr[l]     = 0;
      hdr_cyc[l] = 0;
      trl_cyc[l] = 0;
    end
    @(posedge clk);
    #1;
    do_reset();

    // Single source, 3 words, no backpressure.
    expq[0].push_back(16'hD100);
    expq[0].push_back(16'h0001);
    expq[0].push_back(16'h0002);
    expq[0].push_back(16'h0003);
    expq[0].push_back(16'hE103);
    load(0, 1, 16'h0001, 3);
    wait_drain(0, 40);
    chk("t1_hdr_to_trl_cycles", 32'(trl_cyc[0] - hdr_cyc[0]), 32'd5);

    // All four sources with 2 words: headers in order 0,1,2,3.
    do_reset();
    for (int s = 0; s < NS; s++) expect_burst(0, s, 16'h2001 + 16'(s * 16), 2);
    for (int s = 0; s < NS; s++) load(0, s, 16'h2001 + 16'(s * 16), 2);
    wait_drain(0, 80);

    // MAX_BURST=4, 10 words from source 2: bursts 4, 4, 2.
    do_reset();
    expect_burst(1, 2, 16'h3001, 4);
    expect_burst(1, 2, 16'h3005, 4);
    expect_burst(1, 2, 16'h3009, 2);
    load(1, 2, 16'h3001, 10);
    wait_drain(1, 80);
    chk("t3_last_burst_cycles", 32'(trl_cyc[1] - hdr_cyc[1]), 32'd4);

    // tx_full toggling every other cycle during a 5-word burst.
    do_reset();
    expect_burst(0, 2, 16'h4001, 5);
    load(0, 2, 16'h4001, 5);
    for (int k = 0; k < 24; k++) begin
      tx_full[0] = (k % 2 == 0);
      tick(1);
    end
    tx_full[0] = 1'b0;
    wait_drain(0, 40);

    // Reset after 2 data words of a 6-word burst.
    do_reset();
    expq[0].push_back(16'hD000);
    expq[0].push_back(16'h5001);
    expq[0].push_back(16'h5002);
    load(0, 0, 16'h5001, 6);
    base = nwr[0];
    n = 0;
    while (nwr[0] < base + 3 && n < 40) begin
      tick(1);
      n++;
    end
    chk("t5_words_before_reset", 32'(nwr[0] - base), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tx_en", 32'(tx_en[0]), 32'h0);
    chk("t5_rst_tx_in", 32'(tx_in[0]), 32'h0);
    chk("t5_rst_src_rd", 32'(src_rd[0]), 32'h0);
    chk("t5_pending_expected", 32'(expq[0].size()), 32'd0);
    expq[0].delete();
    tick(2);
    rst_n = 1'b1;
    expect_burst(0, 0, 16'h5003, 4);
    wait_drain(0, 40);

    // Source 0 stays busy, source 3 must still be served: 0, 3, 0, 3.
    do_reset();
    expect_burst(1, 0, 16'h6001, 4);
    expect_burst(1, 3, 16'h6301, 4);
    expect_burst(1, 0, 16'h6005, 4);
    expect_burst(1, 3, 16'h6305, 4);
    load(1, 0, 16'h6001, 8);
    load(1, 3, 16'h6301, 8);
    wait_drain(1, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
